// File: rtl/mvm_noc_loader_pkg.sv
// Shared types for the NoC command loader: FSM states and command word layout.
package mvm_noc_loader_pkg;

  localparam int unsigned TDATAW = 512;
  localparam int unsigned TDESTW = 12;
  localparam int unsigned CMDW   = TDESTW + 1 + TDATAW;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StFin
  } loader_state_t;

  typedef struct packed {
    logic [TDESTW-1:0] tdest;
    logic              tlast;
    logic [TDATAW-1:0] tdata;
  } cmd_word_t;

endpackage

// File: rtl/loader_out_fifo.sv
// Two-entry register FIFO holding prefetched command words; slot0 is always the head.
module loader_out_fifo
  import mvm_noc_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [CMDW-1:0] push_data,
  input  logic            pop,
  output logic [CMDW-1:0] head,
  output logic [1:0]      count
);

  logic [CMDW-1:0] slot0_q, slot0_d;
  logic [CMDW-1:0] slot1_q, slot1_d;
  logic [1:0]      count_q, count_d;
  logic            pop_ok;
  logic            push_ok;
  logic [1:0]      wr_idx;

  // Next-state: pop shifts slot1 forward, push lands in the first free slot after the pop.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pop_ok  = pop && (count_q != 2'd0);
    wr_idx  = count_q - {1'b0, pop_ok};
    push_ok = push && (wr_idx != 2'd2);
    if (pop_ok) begin
      slot0_d = slot1_q;
    end
    if (push_ok) begin
      if (wr_idx == 2'd0) begin
        slot0_d = push_data;
      end else begin
        slot1_d = push_data;
      end
    end
    count_d = count_q - {1'b0, pop_ok} + {1'b0, push_ok};
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/mvm_noc_loader.sv
// Host-side NoC loader: streams a command memory into the mesh, then counts returned results.
module mvm_noc_loader
  import mvm_noc_loader_pkg::*;
#(
  parameter int unsigned MEMDEPTH = 512,
  parameter int unsigned MEMADDRW = $clog2(MEMDEPTH),
  parameter int unsigned RXCNTW   = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [MEMADDRW:0]   NUM_TX,
  input  logic [RXCNTW-1:0]   NUM_RX,
  output logic [MEMADDRW-1:0] mem_raddr,
  output logic                mem_ren,
  input  logic [CMDW-1:0]     mem_rdata,
  output logic                axis_tx_tvalid,
  output logic [TDATAW-1:0]   axis_tx_tdata,
  output logic [TDESTW-1:0]   axis_tx_tdest,
  output logic                axis_tx_tlast,
  input  logic                axis_tx_tready,
  input  logic                axis_rx_tvalid,
  input  logic [TDATAW-1:0]   axis_rx_tdata,
  input  logic [TDESTW-1:0]   axis_rx_tdest,
  input  logic                axis_rx_tlast,
  output logic                axis_rx_tready,
  output logic                BUSY,
  output logic                DONE,
  output logic [RXCNTW-1:0]   RX_COUNT,
  output logic [TDATAW-1:0]   RESULT_DATA
);

  localparam int unsigned CntW = MEMADDRW + 1;

  loader_state_t     state_q, state_d;
  logic [CntW-1:0]   num_tx_q, num_tx_d;
  logic [RXCNTW-1:0] num_rx_q, num_rx_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   sent_q, sent_d;
  logic [RXCNTW-1:0] rx_count_q, rx_count_d;
  logic [TDATAW-1:0] result_q, result_d;
  logic              pend_q;

  logic [CMDW-1:0]   fifo_head;
  logic [1:0]        fifo_count;
  cmd_word_t         head_word;
  logic              tx_pop;
  logic              rx_fire;
  logic [2:0]        slots_used;

  // Destination is irrelevant to the host; any node may reply.
  logic unused_rx_tdest;
  assign unused_rx_tdest = ^axis_rx_tdest;

  loader_out_fifo u_out_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (pend_q),
    .push_data (mem_rdata),
    .pop       (tx_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign head_word      = cmd_word_t'(fifo_head);
  assign axis_tx_tvalid = (fifo_count != 2'd0);
  assign axis_tx_tdata  = head_word.tdata;
  assign axis_tx_tdest  = head_word.tdest;
  assign axis_tx_tlast  = head_word.tlast;
  assign tx_pop         = axis_tx_tvalid && axis_tx_tready;

  // A slot freed by this cycle's pop can be reserved now, which sustains one flit per cycle.
  assign slots_used = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, tx_pop};

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d        = state_q;
    num_tx_d       = num_tx_q;
    num_rx_d       = num_rx_q;
    axis_rx_tready = (state_q == StSend) || (state_q == StWait);
    mem_ren        = (state_q == StSend) && (issued_q < num_tx_q) && (slots_used < 3'd2);
    rx_fire        = axis_rx_tvalid && axis_rx_tready && axis_rx_tlast;
    issued_d       = issued_q + CntW'(mem_ren);
    sent_d         = sent_q + CntW'(tx_pop);
    rx_count_d     = rx_count_q;
    result_d       = result_q;
    if (rx_fire) begin
      result_d = axis_rx_tdata;
      if (rx_count_q != '1) begin
        rx_count_d = rx_count_q + RXCNTW'(1);
      end
    end

    unique case (state_q)
      StIdle, StFin: begin
        if (START) begin
          num_tx_d   = NUM_TX;
          num_rx_d   = NUM_RX;
          rx_count_d = '0;
          issued_d   = '0;
          sent_d     = '0;
          state_d    = (NUM_TX == '0) ? StWait : StSend;
        end
      end
      StSend: begin
        if (tx_pop && (sent_q == num_tx_q - CntW'(1))) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (rx_count_d == num_rx_q) begin
          state_d = StFin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and run registers; reset drops any read still in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      num_tx_q   <= '0;
      num_rx_q   <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      rx_count_q <= '0;
      result_q   <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_tx_q   <= num_tx_d;
      num_rx_q   <= num_rx_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      rx_count_q <= rx_count_d;
      result_q   <= result_d;
      pend_q     <= mem_ren;
    end
  end

  assign mem_raddr   = issued_q[MEMADDRW-1:0];
  assign BUSY        = (state_q == StSend) || (state_q == StWait);
  assign DONE        = (state_q == StFin);
  assign RX_COUNT    = rx_count_q;
  assign RESULT_DATA = result_q;

endmodule

// File: tb/tb_mvm_noc_loader.sv
// Directed bench for mvm_noc_loader with a synchronous-read command memory model.
module tb_mvm_noc_loader;
  import mvm_noc_loader_pkg::*;

  localparam int unsigned MEMDEPTH = 512;
  localparam int unsigned MEMADDRW = 9;
  localparam int unsigned RXCNTW   = 16;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                START = 1'b0;
  logic [MEMADDRW:0]   NUM_TX = '0;
  logic [RXCNTW-1:0]   NUM_RX = '0;
  logic [MEMADDRW-1:0] mem_raddr;
  logic                mem_ren;
  logic [CMDW-1:0]     mem_rdata = '0;
  logic                axis_tx_tvalid;
  logic [TDATAW-1:0]   axis_tx_tdata;
  logic [TDESTW-1:0]   axis_tx_tdest;
  logic                axis_tx_tlast;
  logic                axis_tx_tready = 1'b0;
  logic                axis_rx_tvalid = 1'b0;
  logic [TDATAW-1:0]   axis_rx_tdata = '0;
  logic [TDESTW-1:0]   axis_rx_tdest = '0;
  logic                axis_rx_tlast = 1'b0;
  logic                axis_rx_tready;
  logic                BUSY;
  logic                DONE;
  logic [RXCNTW-1:0]   RX_COUNT;
  logic [TDATAW-1:0]   RESULT_DATA;

  int unsigned     checks = 0;
  int unsigned     failures = 0;
  logic [CMDW-1:0] mem [MEMDEPTH];
  logic [CMDW-1:0] txq [$];
  logic            hold_valid = 1'b0;
  logic [CMDW-1:0] hold_word = '0;
  logic [CMDW-1:0] cur_word;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  mvm_noc_loader #(
    .MEMDEPTH (MEMDEPTH),
    .MEMADDRW (MEMADDRW),
    .RXCNTW   (RXCNTW)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .START          (START),
    .NUM_TX         (NUM_TX),
    .NUM_RX         (NUM_RX),
    .mem_raddr      (mem_raddr),
    .mem_ren        (mem_ren),
    .mem_rdata      (mem_rdata),
    .axis_tx_tvalid (axis_tx_tvalid),
    .axis_tx_tdata  (axis_tx_tdata),
    .axis_tx_tdest  (axis_tx_tdest),
    .axis_tx_tlast  (axis_tx_tlast),
    .axis_tx_tready (axis_tx_tready),
    .axis_rx_tvalid (axis_rx_tvalid),
    .axis_rx_tdata  (axis_rx_tdata),
    .axis_rx_tdest  (axis_rx_tdest),
    .axis_rx_tlast  (axis_rx_tlast),
    .axis_rx_tready (axis_rx_tready),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .RX_COUNT       (RX_COUNT),
    .RESULT_DATA    (RESULT_DATA)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read command memory: data appears one cycle after the read enable.
  always @(posedge CLK) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  assign cur_word = {axis_tx_tdest, axis_tx_tlast, axis_tx_tdata};

  function automatic logic [CMDW-1:0] exp_word(input int unsigned a);
    logic [TDESTW-1:0] d;
    logic [TDATAW-1:0] t;
    logic              l;
    d = TDESTW'(a * 7 + 5);
    l = ((a % 4) == 3);
    t = {16{32'hC0DE_0000 + 32'(a)}};
    return {d, l, t};
  endfunction

  // Called just after a negedge with inputs set; logs handshakes and checks stall stability.
  task automatic tick();
    #1;
    if (hold_valid) chk("tx_stable", {axis_tx_tvalid, cur_word}, {1'b1, hold_word});
    if (axis_tx_tvalid && axis_tx_tready) txq.push_back(cur_word);
    hold_valid = axis_tx_tvalid && !axis_tx_tready;
    hold_word  = cur_word;
    @(negedge CLK);
  endtask

  task automatic rx_beat(input logic last, input logic [TDATAW-1:0] data);
    axis_rx_tvalid = 1'b1;
    axis_rx_tlast  = last;
    axis_rx_tdata  = data;
    axis_rx_tdest  = 12'h3A5;
    tick();
    axis_rx_tvalid = 1'b0;
    axis_rx_tlast  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMDEPTH; i++) mem[i] = exp_word(i);

    // Reset state.
    #1;
    chk("rst_tvalid", axis_tx_tvalid, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_rxcount", RX_COUNT, 16'd0);
    chk("rst_memren", mem_ren, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Run 1: four flits back to back, one result.
    NUM_TX = 10'd4; NUM_RX = 16'd1; axis_tx_tready = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    chk("t1_ren_c1", {mem_ren, mem_raddr}, {1'b1, 9'd0});
    chk("t1_tvalid_c1", axis_tx_tvalid, 1'b0);
    tick();
    chk("t1_ren_c2", {mem_ren, mem_raddr}, {1'b1, 9'd1});
    chk("t1_tvalid_c2", axis_tx_tvalid, 1'b0);
    tick();
    chk("t1_tvalid_c3", axis_tx_tvalid, 1'b1);
    chk("t1_first_word", cur_word, exp_word(0));
    for (int i = 0; i < 4; i++) tick();
    chk("t1_count", txq.size(), 4);
    for (int i = 0; i < 4 && i < txq.size(); i++) chk("t1_flit", txq[i], exp_word(i));
    chk("t1_wait", {axis_tx_tvalid, BUSY, DONE}, 3'b010);
    chk("t1_rxready", axis_rx_tready, 1'b1);
    rx_beat(1'b1, 512'hA5);
    chk("t1_done", DONE, 1'b1);
    chk("t1_rxcount", RX_COUNT, 16'd1);
    chk("t1_result", RESULT_DATA, 512'hA5);
    chk("t1_rxready_fin", axis_rx_tready, 1'b0);

    // Run 2: eight flits with tready pattern 1,0,0; restart from FIN clears RX_COUNT.
    txq.delete();
    NUM_TX = 10'd8; NUM_RX = 16'd0; START = 1'b1;
    tick();
    START = 1'b0;
    chk("t2_restart", {BUSY, DONE, RX_COUNT}, {2'b10, 16'd0});
    for (int k = 0; k < 60 && txq.size() < 8; k++) begin
      axis_tx_tready = ((k % 3) == 0);
      tick();
    end
    axis_tx_tready = 1'b1;
    chk("t2_count", txq.size(), 8);
    for (int i = 0; i < 8 && i < txq.size(); i++) chk("t2_flit", txq[i], exp_word(i));
    for (int k = 0; k < 5 && !DONE; k++) tick();
    chk("t2_done", DONE, 1'b1);

    // Run 3: nothing to send, nothing to receive.
    txq.delete();
    NUM_TX = 10'd0; NUM_RX = 16'd0; START = 1'b1;
    tick();
    START = 1'b0;
    chk("t3_wait", {BUSY, DONE, mem_ren}, 3'b100);
    tick();
    chk("t3_done", {BUSY, DONE}, 2'b01);
    chk("t3_no_tx", txq.size(), 0);

    // Run 4: results during SEND, a non-last beat, START ignored in WAIT.
    NUM_TX = 10'd4; NUM_RX = 16'd2; START = 1'b1;
    tick();
    START = 1'b0;
    rx_beat(1'b1, 512'h11);
    rx_beat(1'b0, 512'h22);
    chk("t4_rx_in_send", {RX_COUNT, RESULT_DATA}, {16'd1, 512'h11});
    for (int k = 0; k < 10 && txq.size() < 4; k++) tick();
    chk("t4_count", txq.size(), 4);
    chk("t4_wait", {BUSY, DONE}, 2'b10);
    NUM_TX = 10'd5; START = 1'b1;
    tick();
    START = 1'b0;
    chk("t4_start_ignored", {BUSY, DONE, mem_ren, axis_tx_tvalid}, 4'b1000);
    rx_beat(1'b1, 512'h33);
    chk("t4_done", {DONE, RX_COUNT}, {1'b1, 16'd2});
    chk("t4_result", RESULT_DATA, 512'h33);

    // Run 5: async reset while a flit is stalled, then a fresh run from address 0.
    txq.delete();
    NUM_TX = 10'd4; NUM_RX = 16'd1; axis_tx_tready = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    chk("t5_held", {axis_tx_tvalid, cur_word}, {1'b1, exp_word(0)});
    hold_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("t5_rst_tx", {axis_tx_tvalid, axis_tx_tdata, axis_tx_tdest, axis_tx_tlast},
        {1'b0, 512'd0, 12'd0, 1'b0});
    chk("t5_rst_ctl", {mem_ren, mem_raddr, BUSY, DONE, axis_rx_tready}, 13'd0);
    chk("t5_rst_rx", {RX_COUNT, RESULT_DATA}, {16'd0, 512'd0});
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    NUM_TX = 10'd2; axis_tx_tready = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    chk("t5_restart_addr", {mem_ren, mem_raddr}, {1'b1, 9'd0});
    for (int k = 0; k < 10 && txq.size() < 2; k++) tick();
    chk("t5_count", txq.size(), 2);
    if (txq.size() > 0) chk("t5_flit0", txq[0], exp_word(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvm_noc_loader.md
# mvm_noc_loader

Host-side AXI-S endpoint that attaches to one mesh router port and drives the MVM tiles over the NoC. On START it streams a preloaded command sequence (instructions, vectors, matrix rows), with a per-flit tdest, from a synchronous-read command memory into the mesh. It then collects result packets returned by the MVM tiles and raises DONE once the programmed number of result packets has arrived. It is the transmitter for the tiles' `axis_rx` ports and the receiver for their `axis_tx` ports.

## Interface
- TDATAW, 512, flit payload width
- TDESTW, 12, destination node ID width
- MEMDEPTH, 512, command memory entries
- MEMADDRW, $clog2(MEMDEPTH), command address width
- RXCNTW, 16, result packet counter width
- CLK  in  1  single clock (user domain); all logic is rising-edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  single-cycle start pulse
- NUM_TX  in  MEMADDRW+1  flits to send (0..MEMDEPTH)
- NUM_RX  in  RXCNTW  result packets expected
- mem_raddr  out  MEMADDRW  command memory read address
- mem_ren  out  1  command memory read enable
- mem_rdata  in  TDESTW+1+TDATAW  {tdest, tlast, tdata}, valid 1 cycle after mem_ren
- axis_tx_tvalid / tdata / tdest / tlast  out  1 / TDATAW / TDESTW / 1  flits into the mesh
- axis_tx_tready  in  1
- axis_rx_tvalid / tdata / tdest / tlast  in  1 / TDATAW / TDESTW / 1  results from the mesh
- axis_rx_tready  out  1
- BUSY  out  1  high in SEND or WAIT
- DONE  out  1  high in FIN
- RX_COUNT  out  RXCNTW  result packets received this run
- RESULT_DATA  out  TDATAW  tdata of the most recent tlast beat received

## Operation
- FSM states: IDLE, SEND, WAIT, FIN.
- IDLE: START latches NUM_TX/NUM_RX, clears RX_COUNT and read/send counters, and moves to SEND. If NUM_TX==0, it moves to WAIT instead.
- SEND: prefetches memory addresses 0..NUM_TX-1 into a 2-entry output FIFO.
  - A read is issued when (FIFO occupancy + reads in flight) < 2 and issued < NUM_TX.
  - The FIFO head drives axis_tx.
  - The state moves to WAIT on the cycle the NUM_TX-th flit handshakes.
- WAIT: moves to FIN when RX_COUNT == NUM_RX. This is checked after the current cycle's increment. If NUM_RX==0, FIN follows one cycle after entering WAIT.
- FIN: DONE=1. START restarts a run (same as from IDLE). Outputs hold otherwise.
- START in SEND or WAIT is ignored.
- axis_rx_tready = 1 in SEND and WAIT, 0 in IDLE and FIN. Results that arrive during SEND are counted.
- Each rx beat with tvalid&tready&tlast increments RX_COUNT and captures RESULT_DATA. Non-last beats are accepted and discarded.
- RX_COUNT saturates at all-ones; it never wraps.
- Any rx_tdest value is accepted.

## Timing
- Reset values: all outputs 0, FSM=IDLE, FIFO empty.
- Async reset mid-run aborts immediately. In-flight flits and pending reads are dropped, and tvalid is 0 while RST_N is low.
- mem_rdata is consumed exactly 1 cycle after mem_ren. It is never stalled, because the reservation rule guarantees a free FIFO slot.
- START to first mem_ren: 1 cycle. START to first axis_tx_tvalid: 3 cycles.
- Sustained throughput: 1 flit/cycle while tready=1.
- AXI-S rules: once tvalid is high, tvalid, tdata, tdest and tlast stay stable until tready. tvalid never depends combinationally on tready. tready may toggle arbitrarily.
- A simultaneous FIFO push and pop keeps occupancy unchanged.
- DONE rises the cycle after the final tlast beat is accepted (or per the NUM_RX==0 rule). It falls the cycle after a START accepted in FIN.

## Structure
- Shared package: FSM state enum `loader_state_t`, the command word layout (`cmd_word_t` packed struct {tdest, tlast, tdata}), and TDATAW/TDESTW from the existing parameters file.
- One sub-module: `loader_out_fifo`, a 2-entry register FIFO with push/pop, count, and head outputs.

## Test plan
- NUM_TX=4, NUM_RX=1, tready always 1 -> 4 consecutive flits with memory tdest/tlast, first tvalid 3 cycles after START. One rx tlast beat with tdata=0xA5 -> DONE=1, RX_COUNT=1, RESULT_DATA=0xA5.
- NUM_TX=8 with tready toggling 1,0,0,1… -> no flit lost or duplicated, and flit order matches addresses 0..7; payload is stable while stalled.
- NUM_TX=0, NUM_RX=0 -> IDLE→WAIT→FIN, DONE 2 cycles after START, no tvalid.
- Result beats arriving during SEND (NUM_RX=2, one during SEND, one in WAIT) -> RX_COUNT=2, DONE. A non-last beat does not increment RX_COUNT.
- RST_N low for 1 cycle mid-SEND with tvalid held -> all outputs 0 immediately. A new START afterward sends from address 0.
- START pulsed again during WAIT -> ignored. START in FIN -> RX_COUNT clears and a new run begins.
